// File: rtl/s_link_pkg.sv
// ----------------------------------------------------------------------------
// s_link_pkg
// Constants and types shared by the S1 serial transmitter and the S2 serial
// receiver. A packet is ADDR_BITS address bits followed by DATA_BITS data
// bits, both MSB first; NUM_PKT successful writes complete a transfer.
// ----------------------------------------------------------------------------
package s_link_pkg;

    localparam int ADDR_BITS = 3;
    localparam int DATA_BITS = 18;
    localparam int NUM_PKT   = 8;
    localparam int PKT_BITS  = ADDR_BITS + DATA_BITS;

    // Receiver control states: RECV after reset, DONE is terminal.
    typedef enum logic [0:0] {
        RECV = 1'b0,
        DONE = 1'b1
    } rx_state_e;

endpackage : s_link_pkg

// File: rtl/s2_serial_rx_if.sv
// ----------------------------------------------------------------------------
// s2_serial_rx_if
// Serial link plus RB2 write port of the S2 receiver.
//   sen     : serial enable, active low (driven by the source)
//   sd      : serial data, valid while sen is low (driven by the source)
//   RB2_RW  : RB2 control, 1 = idle/read, 0 = write strobe (receiver)
//   RB2_A   : RB2 write address (receiver)
//   RB2_D   : RB2 write data (receiver)
//   done    : sticky completion flag (receiver)
//   err     : one-cycle malformed-packet pulse (receiver)
// Modports: master = serial source / bench side, slave = receiver side.
// ----------------------------------------------------------------------------
interface s2_serial_rx_if #(
    parameter int ADDR_BITS = s_link_pkg::ADDR_BITS,
    parameter int DATA_BITS = s_link_pkg::DATA_BITS
);

    logic                 sen;
    logic                 sd;
    logic                 RB2_RW;
    logic [ADDR_BITS-1:0] RB2_A;
    logic [DATA_BITS-1:0] RB2_D;
    logic                 done;
    logic                 err;

    modport master (
        output sen,
        output sd,
        input  RB2_RW,
        input  RB2_A,
        input  RB2_D,
        input  done,
        input  err
    );

    modport slave (
        input  sen,
        input  sd,
        output RB2_RW,
        output RB2_A,
        output RB2_D,
        output done,
        output err
    );

endinterface : s2_serial_rx_if

// File: rtl/s_shift_in.sv
// ----------------------------------------------------------------------------
// s_shift_in
// Serial-in shift register with a saturating bit counter.
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset
//   shift_en : shift sd in (LSB side) and count the bit
//   clr      : clear the bit counter (packet end); shift_en has priority
//   sd       : serial data bit
//   shreg    : WIDTH-bit shift register, most recent bit in bit 0
//   bit_cnt  : bits received, saturating at WIDTH+1 (overrun marker)
// Once the counter sits at the overrun marker further bits are ignored, so
// neither the counter nor the register content wraps.
// ----------------------------------------------------------------------------
module s_shift_in #(
    parameter int WIDTH = s_link_pkg::PKT_BITS,
    parameter int CNT_W = $clog2(s_link_pkg::PKT_BITS + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             clr,
    input  logic             sd,
    output logic [WIDTH-1:0] shreg,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);

    logic [WIDTH-1:0] shreg_r;
    logic [WIDTH-1:0] shreg_nx;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nx;

    // Next shift-register and counter values.
    always_comb begin
        shreg_nx = shreg_r;
        cnt_nx   = cnt_r;
        if (shift_en) begin
            if (cnt_r != CNT_SAT) begin
                shreg_nx = {shreg_r[WIDTH-2:0], sd};
                cnt_nx   = cnt_r + CNT_ONE;
            end else begin
                shreg_nx = shreg_r;
                cnt_nx   = cnt_r;
            end
        end else if (clr) begin
            cnt_nx = CNT_ZERO;
        end else begin
            cnt_nx = cnt_r;
        end
    end

    // Shift register and counter state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_r <= {WIDTH{1'b0}};
            cnt_r   <= CNT_ZERO;
        end else begin
            shreg_r <= shreg_nx;
            cnt_r   <= cnt_nx;
        end
    end

    assign shreg   = shreg_r;
    assign bit_cnt = cnt_r;

endmodule : s_shift_in

// File: rtl/s2_serial_rx.sv
// ----------------------------------------------------------------------------
// s2_serial_rx
// Serial receiver paired with the S1 transmitter. Deserialises sen/sd packets
// (ADDR_BITS address + DATA_BITS data, MSB first) and issues one-cycle write
// strobes into register bank RB2. After NUM_PKT good writes it enters DONE,
// raises the sticky done flag and ignores the link until reset.
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : s2_serial_rx_if slave (sen, sd in; RB2_RW, RB2_A, RB2_D, done, err out)
// A packet ends on the first high sample of sen after at least one low
// sample; exactly PKT_BITS low samples make a write, any other count pulses
// err. All outputs are registered, so the strobe, done and err appear right
// after the edge that samples the packet end.
// ----------------------------------------------------------------------------
module s2_serial_rx #(
    parameter int ADDR_BITS = s_link_pkg::ADDR_BITS,
    parameter int DATA_BITS = s_link_pkg::DATA_BITS,
    parameter int NUM_PKT   = s_link_pkg::NUM_PKT
) (
    input  logic           clk,
    input  logic           rst,
    s2_serial_rx_if.slave  bus
);

    import s_link_pkg::*;

    localparam int PKT_W = ADDR_BITS + DATA_BITS;
    localparam int CNT_W = $clog2(PKT_W + 2);
    localparam int WR_W  = $clog2(NUM_PKT + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);
    localparam logic [CNT_W-1:0] PKT_LEN  = CNT_W'(PKT_W);
    localparam logic [WR_W-1:0]  WR_ONE   = WR_W'(1'b1);
    localparam logic [WR_W-1:0]  WR_LAST  = WR_W'(NUM_PKT - 1);

    rx_state_e            state_r;
    rx_state_e            state_nx;

    logic                 shift_en_s;
    logic                 pkt_end_s;
    logic                 pkt_ok_s;
    logic [PKT_W-1:0]     shreg_s;
    logic [CNT_W-1:0]     bit_cnt_s;

    logic                 rw_r;
    logic                 rw_nx;
    logic [ADDR_BITS-1:0] a_r;
    logic [ADDR_BITS-1:0] a_nx;
    logic [DATA_BITS-1:0] d_r;
    logic [DATA_BITS-1:0] d_nx;
    logic                 done_r;
    logic                 done_nx;
    logic                 err_r;
    logic                 err_nx;
    logic [WR_W-1:0]      wr_cnt_r;
    logic [WR_W-1:0]      wr_cnt_nx;

    // Link decode: only RECV listens to the link; DONE freezes the shifter.
    always_comb begin
        shift_en_s = 1'b0;
        pkt_end_s  = 1'b0;
        pkt_ok_s   = 1'b0;
        if (state_r == RECV) begin
            shift_en_s = ~bus.sen;
            pkt_end_s  = bus.sen & (bit_cnt_s != CNT_ZERO);
            pkt_ok_s   = bus.sen & (bit_cnt_s == PKT_LEN);
        end else begin
            shift_en_s = 1'b0;
            pkt_end_s  = 1'b0;
            pkt_ok_s   = 1'b0;
        end
    end

    s_shift_in #(
        .WIDTH (PKT_W),
        .CNT_W (CNT_W)
    ) u_shift_in (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en_s),
        .clr      (pkt_end_s),
        .sd       (bus.sd),
        .shreg    (shreg_s),
        .bit_cnt  (bit_cnt_s)
    );

    // Next state and next RB2/status outputs; strobe and err default inactive.
    always_comb begin
        state_nx  = state_r;
        rw_nx     = 1'b1;
        a_nx      = a_r;
        d_nx      = d_r;
        done_nx   = done_r;
        err_nx    = 1'b0;
        wr_cnt_nx = wr_cnt_r;
        case (state_r)
            RECV: begin
                if (pkt_ok_s) begin
                    // First address bit received is now the MSB of shreg.
                    rw_nx     = 1'b0;
                    a_nx      = shreg_s[PKT_W-1:DATA_BITS];
                    d_nx      = shreg_s[DATA_BITS-1:0];
                    wr_cnt_nx = wr_cnt_r + WR_ONE;
                    if (wr_cnt_r == WR_LAST) begin
                        state_nx = DONE;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx = RECV;
                    end
                end else if (pkt_end_s) begin
                    err_nx = 1'b1;
                end else begin
                    err_nx = 1'b0;
                end
            end
            DONE: begin
                state_nx = DONE;
                done_nx  = 1'b1;
            end
            default: begin
                state_nx = RECV;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= RECV;
        end else begin
            state_r <= state_nx;
        end
    end

    // Registered RB2 write port, status flags and write counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rw_r     <= 1'b1;
            a_r      <= {ADDR_BITS{1'b0}};
            d_r      <= {DATA_BITS{1'b0}};
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            wr_cnt_r <= {WR_W{1'b0}};
        end else begin
            rw_r     <= rw_nx;
            a_r      <= a_nx;
            d_r      <= d_nx;
            done_r   <= done_nx;
            err_r    <= err_nx;
            wr_cnt_r <= wr_cnt_nx;
        end
    end

    assign bus.RB2_RW = rw_r;
    assign bus.RB2_A  = a_r;
    assign bus.RB2_D  = d_r;
    assign bus.done   = done_r;
    assign bus.err    = err_r;

endmodule : s2_serial_rx

// File: tb/tb_s2_serial_rx.sv
// ----------------------------------------------------------------------------
// tb_s2_serial_rx
// Self-checking bench for s2_serial_rx: directed corner sequences, a table of
// single-packet vectors, and a random packet stream scored against a
// packet-level reference model.
// ----------------------------------------------------------------------------
module tb_s2_serial_rx;

    import s_link_pkg::*;

    typedef struct packed {
        logic [ADDR_BITS-1:0] a;
        logic [DATA_BITS-1:0] d;
    } wr_t;

    typedef struct {
        int          len;
        logic [31:0] bits;
        logic        exp_wr;
        logic [2:0]  exp_a;
        logic [17:0] exp_d;
        logic        exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total;
    int   bad;
    int   err_cyc = 0;
    wr_t  obs_q[$];
    wr_t  exp_q[$];
    vec_t vecs[8];

    always #5 clk = ~clk;

    s2_serial_rx_if bus ();

    s2_serial_rx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Monitor: record every strobe cycle and every err-high cycle.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (bus.RB2_RW === 1'b0) obs_q.push_back({bus.RB2_A, bus.RB2_D});
            if (bus.err === 1'b1) err_cyc <= err_cyc + 1;
        end
    end

    // Watchdog.
    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Send the low len bits of 'bits', MSB first, with sen low.
    task automatic drive_bits(input logic [31:0] bits, input int len);
        for (int i = len - 1; i >= 0; i--) begin
            @(negedge clk);
            bus.sen = 1'b0;
            bus.sd  = bits[i];
        end
    endtask

    // Hold sen high for gap cycles.
    task automatic idle(input int gap);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            bus.sen = 1'b1;
            bus.sd  = 1'b0;
        end
    endtask

    function automatic logic [31:0] word(input int a, input int d);
        return (32'(a) << DATA_BITS) | (32'(d) & 32'h3FFFF);
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rw"},   32'(bus.RB2_RW), 32'd1);
        check({tag, "_a"},    32'(bus.RB2_A),  32'd0);
        check({tag, "_d"},    32'(bus.RB2_D),  32'd0);
        check({tag, "_done"}, 32'(bus.done),   32'd0);
        check({tag, "_err"},  32'(bus.err),    32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.sen = 1'b1;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int base_w;
        int base_e;
        int exp_w;
        int exp_e;
        int len;
        int gap;
        int mdl_wr;
        logic mdl_done;
        logic [31:0] bits;
        logic [31:0] w;
        wr_t  e;

        total = 0;
        bad   = 0;
        rst   = 1'b0;
        bus.sen = 1'b1;
        bus.sd  = 1'b0;

        vecs[0] = '{15, 32'h0000_5555, 1'b0, 3'd5, 18'h2A5C3, 1'b1};
        vecs[1] = '{21, 32'h000B_FFFF, 1'b1, 3'd2, 18'h3FFFF, 1'b0};
        vecs[2] = '{21, 32'h0000_0000, 1'b1, 3'd0, 18'h00000, 1'b0};
        vecs[3] = '{1,  32'h0000_0001, 1'b0, 3'd0, 18'h00000, 1'b1};
        vecs[4] = '{22, 32'h002A_AAAA, 1'b0, 3'd0, 18'h00000, 1'b1};
        vecs[5] = '{21, 32'h001D_5A5A, 1'b1, 3'd7, 18'h15A5A, 1'b0};
        vecs[6] = '{20, 32'h000F_FFFF, 1'b0, 3'd7, 18'h15A5A, 1'b1};
        vecs[7] = '{21, 32'h0010_0001, 1'b1, 3'd4, 18'h00001, 1'b0};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        // Single packet: address 5, data 2A5C3, exact strobe timing.
        base_w = obs_q.size();
        base_e = err_cyc;
        drive_bits(word(5, 18'h2A5C3), 21);
        @(negedge clk);
        bus.sen = 1'b1;
        check("single_pre_rw", 32'(bus.RB2_RW), 32'd1);
        @(posedge clk); #1;
        check("single_rw", 32'(bus.RB2_RW), 32'd0);
        check("single_a",  32'(bus.RB2_A),  32'd5);
        check("single_d",  32'(bus.RB2_D),  32'h2A5C3);
        check("single_err", 32'(bus.err),   32'd0);
        @(posedge clk); #1;
        check("single_rw_after", 32'(bus.RB2_RW), 32'd1);
        exp_w = 1;
        exp_e = 0;

        // Table of single packets, one-cycle gaps.
        for (int v = 0; v < 8; v++) begin
            drive_bits(vecs[v].bits, vecs[v].len);
            @(negedge clk);
            bus.sen = 1'b1;
            @(posedge clk); #1;
            check($sformatf("vec%0d_rw", v),  32'(bus.RB2_RW), 32'(!vecs[v].exp_wr));
            check($sformatf("vec%0d_a", v),   32'(bus.RB2_A),  32'(vecs[v].exp_a));
            check($sformatf("vec%0d_d", v),   32'(bus.RB2_D),  32'(vecs[v].exp_d));
            check($sformatf("vec%0d_err", v), 32'(bus.err),    32'(vecs[v].exp_err));
            if (vecs[v].exp_wr) exp_w++;
            if (vecs[v].exp_err) exp_e++;
        end

        // Long packet: counter saturates, err pulses for exactly one cycle.
        drive_bits(32'h01AB_CDEF, 25);
        @(negedge clk);
        check("long_bitcnt_sat", 32'(dut.bit_cnt_s), 32'd22);
        bus.sen = 1'b1;
        @(posedge clk); #1;
        check("long_err", 32'(bus.err), 32'd1);
        check("long_rw",  32'(bus.RB2_RW), 32'd1);
        @(posedge clk); #1;
        check("long_err_fall", 32'(bus.err), 32'd0);
        exp_e++;

        // Three more good packets; the last one is the eighth write.
        drive_bits(word(1, 18'h0F0F0), 21);
        idle(1);
        @(posedge clk); #1;
        check("after_long_a", 32'(bus.RB2_A), 32'd1);
        check("after_long_d", 32'(bus.RB2_D), 32'h0F0F0);
        drive_bits(word(3, 18'h2468A), 21);
        idle(1);
        drive_bits(word(6, 18'h3C3C3), 21);
        @(negedge clk);
        bus.sen = 1'b1;
        check("done_before_last", 32'(bus.done), 32'd0);
        @(posedge clk); #1;
        check("last_rw",   32'(bus.RB2_RW), 32'd0);
        check("last_done", 32'(bus.done),   32'd1);
        check("last_d",    32'(bus.RB2_D),  32'h3C3C3);
        exp_w += 3;

        // After done: ninth packet and a short packet are ignored.
        drive_bits(word(4, 18'h12345), 21);
        idle(1);
        @(posedge clk); #1;
        check("post_done_rw", 32'(bus.RB2_RW), 32'd1);
        check("post_done_a",  32'(bus.RB2_A),  32'd6);
        check("post_done_d",  32'(bus.RB2_D),  32'h3C3C3);
        drive_bits(32'h0000_03FF, 10);
        idle(1);
        @(posedge clk); #1;
        check("post_done_err",  32'(bus.err),  32'd0);
        check("post_done_done", 32'(bus.done), 32'd1);
        idle(2);
        check("seg1_strobes", 32'(obs_q.size() - base_w), 32'(exp_w));
        check("seg1_err_cycles", 32'(err_cyc - base_e), 32'(exp_e));

        // Reset at bit 10 of packet 4.
        pulse_reset();
        for (int p = 0; p < 3; p++) begin
            drive_bits(word(p + 1, 18'h11111 * (p + 1)), 21);
            idle(1);
        end
        drive_bits(word(4, 18'h2AAAA) >> 11, 10);
        #2 rst = 1'b0;
        #1 check_reset_outputs("midpkt_reset");
        bus.sen = 1'b1;
        @(negedge clk);
        rst = 1'b1;

        // Reset while a strobe is pending clears it at once.
        drive_bits(word(2, 18'h00ABC), 21);
        @(negedge clk);
        bus.sen = 1'b1;
        @(posedge clk); #1;
        check("pending_rw_low", 32'(bus.RB2_RW), 32'd0);
        #2 rst = 1'b0;
        #1 check("pending_rw_forced", 32'(bus.RB2_RW), 32'd1);
        check("pending_a_cleared", 32'(bus.RB2_A), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Fresh eight-packet stream, addresses 0..7.
        base_w = obs_q.size();
        exp_q.delete();
        for (int p = 0; p < NUM_PKT; p++) begin
            w = word(p, int'($urandom_range(0, 32'h3FFFF)));
            e.a = 3'(w >> DATA_BITS);
            e.d = 18'(w);
            exp_q.push_back(e);
            drive_bits(w, PKT_BITS);
            idle(1);
        end
        idle(3);
        check("fresh_strobes", 32'(obs_q.size() - base_w), 32'(NUM_PKT));
        for (int i = 0; i < NUM_PKT && base_w + i < obs_q.size(); i++)
            check($sformatf("fresh_wr%0d", i), 32'(obs_q[base_w + i]), 32'(exp_q[i]));
        check("fresh_done", 32'(bus.done), 32'd1);

        // Random stream against the packet-level model.
        pulse_reset();
        base_w = obs_q.size();
        base_e = err_cyc;
        exp_q.delete();
        exp_e    = 0;
        mdl_wr   = 0;
        mdl_done = 1'b0;
        for (int p = 0; p < 30; p++) begin
            len  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 26)) : PKT_BITS;
            bits = $urandom();
            gap  = int'($urandom_range(1, 3));
            if (!mdl_done) begin
                if (len == PKT_BITS) begin
                    e.a = 3'((bits >> DATA_BITS) & 32'h7);
                    e.d = 18'(bits & 32'h3FFFF);
                    exp_q.push_back(e);
                    mdl_wr++;
                    if (mdl_wr == NUM_PKT) mdl_done = 1'b1;
                end else begin
                    exp_e++;
                end
            end
            drive_bits(bits, len);
            idle(gap);
        end
        idle(3);
        check("rand_strobes", 32'(obs_q.size() - base_w), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && base_w + i < obs_q.size(); i++)
            check($sformatf("rand_wr%0d", i), 32'(obs_q[base_w + i]), 32'(exp_q[i]));
        check("rand_err_cycles", 32'(err_cyc - base_e), 32'(exp_e));
        check("rand_done", 32'(bus.done), 32'(mdl_done));
        if (exp_q.size() > 0) begin
            check("rand_last_a", 32'(bus.RB2_A), 32'(exp_q[exp_q.size() - 1].a));
            check("rand_last_d", 32'(bus.RB2_D), 32'(exp_q[exp_q.size() - 1].d));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_s2_serial_rx
